iob_fifo_sync: RTL and testbench



---
 rtl/iob_fifo_sync.sv | 78 +++++++
 tb/tb_iob_fifo_sync.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/iob_fifo_sync.sv
// iob_fifo_sync: synchronous FIFO controller driving an external
// two-port RAM (one write port, one registered read port, 1-cycle latency).
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   w_en, w_data, w_full         push side
//   r_en, r_data, r_valid        pop side, data valid the cycle after pop
//   r_empty, level               status from registered occupancy
//   ext_mem_w_en/_addr/_data     RAM write port strobes
//   ext_mem_r_en/_addr           RAM read port strobes
//   ext_mem_r_data               RAM registered read data
module iob_fifo_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_full,
    input  logic              r_en,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              r_empty,
    output logic [ADDR_W:0]   level,
    output logic              ext_mem_w_en,
    output logic [ADDR_W-1:0] ext_mem_w_addr,
    output logic [DATA_W-1:0] ext_mem_w_data,
    output logic              ext_mem_r_en,
    output logic [ADDR_W-1:0] ext_mem_r_addr,
    input  logic [DATA_W-1:0] ext_mem_r_data
);

    localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   level_q;
    logic              r_valid_q;
    logic              push;
    logic              pop;

    assign w_full  = (level_q == FULL_LVL);
    assign r_empty = (level_q == '0);

    // Gated by rst_n so the RAM sees no strobe while reset is held.
    assign push = w_en & ~w_full & rst_n;
    assign pop  = r_en & ~r_empty & rst_n;

    assign ext_mem_w_en   = push;
    assign ext_mem_w_addr = wptr;
    assign ext_mem_w_data = w_data;
    assign ext_mem_r_en   = pop;
    assign ext_mem_r_addr = rptr;

    assign r_data  = ext_mem_r_data;
    assign r_valid = r_valid_q;
    assign level   = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            level_q   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= pop;
            if (push) wptr <= wptr + ADDR_W'(1);
            if (pop)  rptr <= rptr + ADDR_W'(1);
            unique case ({push, pop})
                2'b10:   level_q <= level_q + (ADDR_W+1)'(1);
                2'b01:   level_q <= level_q - (ADDR_W+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_fifo_sync.sv
// tb_iob_fifo_sync: directed table + corner sequences + random queue
// model for iob_fifo_sync with ADDR_W=2, DATA_W=8 and a behavioural RAM.
module tb_iob_fifo_sync;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          w_en;
    logic [DW-1:0] w_data;
    logic          w_full;
    logic          r_en;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_empty;
    logic [AW:0]   level;
    logic          m_w_en;
    logic [AW-1:0] m_w_addr;
    logic [DW-1:0] m_w_data;
    logic          m_r_en;
    logic [AW-1:0] m_r_addr;
    logic [DW-1:0] m_r_data;

    int checks = 0;
    int errors = 0;

    iob_fifo_sync #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .w_en           (w_en),
        .w_data         (w_data),
        .w_full         (w_full),
        .r_en           (r_en),
        .r_data         (r_data),
        .r_valid        (r_valid),
        .r_empty        (r_empty),
        .level          (level),
        .ext_mem_w_en   (m_w_en),
        .ext_mem_w_addr (m_w_addr),
        .ext_mem_w_data (m_w_data),
        .ext_mem_r_en   (m_r_en),
        .ext_mem_r_addr (m_r_addr),
        .ext_mem_r_data (m_r_data)
    );

    logic [DW-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (m_w_en) mem[m_w_addr] <= m_w_data;
        if (m_r_en) m_r_data <= mem[m_r_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          we;
        logic [DW-1:0] wd;
        logic          re;
        logic          ew;
        logic          er;
        logic [AW:0]   lvl;
        logic          full;
        logic          empty;
        logic          rv;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t tbl [18];

    logic [DW-1:0] q [$];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    initial begin
        rst_n  = 1'b0;
        w_en   = 1'b0;
        r_en   = 1'b0;
        w_data = '0;

        // we wd re | ew er lvl full empty rv rd
        tbl[0]  = '{1, 8'h11, 0, 1, 0, 1, 0, 0, 0, 8'h00};
        tbl[1]  = '{1, 8'h22, 0, 1, 0, 2, 0, 0, 0, 8'h00};
        tbl[2]  = '{1, 8'h33, 0, 1, 0, 3, 0, 0, 0, 8'h00};
        tbl[3]  = '{1, 8'h44, 0, 1, 0, 4, 1, 0, 0, 8'h00};
        tbl[4]  = '{1, 8'h55, 0, 0, 0, 4, 1, 0, 0, 8'h00};
        tbl[5]  = '{0, 8'h00, 1, 0, 1, 3, 0, 0, 1, 8'h11};
        tbl[6]  = '{0, 8'h00, 1, 0, 1, 2, 0, 0, 1, 8'h22};
        tbl[7]  = '{1, 8'h66, 1, 1, 1, 2, 0, 0, 1, 8'h33};
        tbl[8]  = '{0, 8'h00, 1, 0, 1, 1, 0, 0, 1, 8'h44};
        tbl[9]  = '{0, 8'h00, 1, 0, 1, 0, 0, 1, 1, 8'h66};
        tbl[10] = '{0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 8'h00};
        tbl[11] = '{1, 8'h77, 1, 1, 0, 1, 0, 0, 0, 8'h00};
        tbl[12] = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00};
        tbl[13] = '{1, 8'h88, 0, 1, 0, 2, 0, 0, 0, 8'h00};
        tbl[14] = '{1, 8'h99, 0, 1, 0, 3, 0, 0, 0, 8'h00};
        tbl[15] = '{1, 8'hAA, 0, 1, 0, 4, 1, 0, 0, 8'h00};
        tbl[16] = '{1, 8'hBB, 1, 0, 1, 3, 0, 0, 1, 8'h77};
        tbl[17] = '{0, 8'h00, 0, 0, 0, 3, 0, 0, 0, 8'h00};

        #12;
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(r_empty), 1);
        chk("rst_full", 32'(w_full), 0);
        chk("rst_rvalid", 32'(r_valid), 0);
        chk("rst_waddr", 32'(m_w_addr), 0);
        chk("rst_raddr", 32'(m_r_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            w_en   = tbl[i].we;
            w_data = tbl[i].wd;
            r_en   = tbl[i].re;
            #1;
            chk($sformatf("v%0d_mwen", i), 32'(m_w_en), 32'(tbl[i].ew));
            chk($sformatf("v%0d_mren", i), 32'(m_r_en), 32'(tbl[i].er));
            if (tbl[i].ew && tbl[i].er)
                chk($sformatf("v%0d_adiff", i),
                    32'(m_w_addr != m_r_addr), 1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("v%0d_full", i), 32'(w_full), 32'(tbl[i].full));
            chk($sformatf("v%0d_empty", i), 32'(r_empty),
                32'(tbl[i].empty));
            chk($sformatf("v%0d_rvalid", i), 32'(r_valid), 32'(tbl[i].rv));
            if (tbl[i].rv)
                chk($sformatf("v%0d_rdata", i), 32'(r_data),
                    32'(tbl[i].rd));
        end

        // Reset mid-traffic with a pop in flight
        @(negedge clk);
        w_en   = 1'b1;
        w_data = 8'hCC;
        r_en   = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rvalid_pre", 32'(r_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rvalid", 32'(r_valid), 0);
        chk("mid_level", 32'(level), 0);
        chk("mid_empty", 32'(r_empty), 1);
        chk("mid_full", 32'(w_full), 0);
        chk("mid_mwen", 32'(m_w_en), 0);
        chk("mid_mren", 32'(m_r_en), 0);
        chk("mid_waddr", 32'(m_w_addr), 0);
        chk("mid_raddr", 32'(m_r_addr), 0);
        w_en = 1'b0;
        r_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap-around: interleaved push/pop of 0..9
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            w_en   = 1'b1;
            w_data = 8'(i);
            r_en   = 1'b0;
            #1;
            chk($sformatf("wr%0d_waddr", i), 32'(m_w_addr), 32'(i % 4));
            @(negedge clk);
            w_en = 1'b0;
            r_en = 1'b1;
            #1;
            chk($sformatf("wr%0d_raddr", i), 32'(m_r_addr), 32'(i % 4));
            @(posedge clk);
            #1;
            chk($sformatf("wr%0d_rvalid", i), 32'(r_valid), 1);
            chk($sformatf("wr%0d_rdata", i), 32'(r_data), 32'(i));
        end
        @(negedge clk);
        r_en = 1'b0;
        #1;
        chk("wr_empty", 32'(r_empty), 1);

        // Random traffic against a queue model; pointers are at 10%4=2
        wp = 2'd2;
        rp = 2'd2;
        q.delete();
        for (int c = 0; c < 1000; c++) begin
            logic mp;
            logic mo;
            logic [DW-1:0] exp_d;
            @(negedge clk);
            w_en   = 1'($urandom_range(0, 1));
            r_en   = 1'($urandom_range(0, 1));
            w_data = 8'($urandom);
            mp = w_en && (q.size() < DEPTH);
            mo = r_en && (q.size() > 0);
            #1;
            chk("rnd_mwen", 32'(m_w_en), 32'(mp));
            chk("rnd_mren", 32'(m_r_en), 32'(mo));
            if (mp) chk("rnd_waddr", 32'(m_w_addr), 32'(wp));
            if (mo) chk("rnd_raddr", 32'(m_r_addr), 32'(rp));
            exp_d = '0;
            if (mo) begin
                exp_d = q.pop_front();
                rp = rp + 2'd1;
            end
            if (mp) begin
                q.push_back(w_data);
                wp = wp + 2'd1;
            end
            @(posedge clk);
            #1;
            chk("rnd_rvalid", 32'(r_valid), 32'(mo));
            if (mo) chk("rnd_rdata", 32'(r_data), 32'(exp_d));
            chk("rnd_level", 32'(level), 32'(q.size()));
            chk("rnd_full", 32'(w_full), 32'(q.size() == DEPTH));
            chk("rnd_empty", 32'(r_empty), 32'(q.size() == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
